// File: rtl/booth_mult_ctrl_if.sv
// booth_mult_ctrl_if
//   Start/done handshake and operand/result bundle for booth_mult_ctrl.
//   Parameter dw: operand width in bits; the product is 2*dw bits.
//   master: drives start/multiplicand/multiplier and observes busy/done/product.
//   slave : the multiplier controller side.
interface booth_mult_ctrl_if #(
  parameter int dw = 8
);
  logic            start;
  logic [dw-1:0]   multiplicand;
  logic [dw-1:0]   multiplier;
  logic            busy;
  logic            done;
  logic [2*dw-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl
//   Sequential radix-2 Booth multiplier for signed two's-complement operands.
//   It drives one shared (dw+1)-bit adder/subtractor through dw
//   add/sub-then-shift iterations and returns a 2*dw-bit signed product.
//
// Ports
//   clk    : system clock; all state changes on the rising edge
//   reset  : synchronous, active-high reset
//   bus    : booth_mult_ctrl_if.slave
//            start        (in)  request, sampled only in IDLE
//            multiplicand (in)  signed M, sampled on an accepted start
//            multiplier   (in)  signed Q, sampled on an accepted start
//            busy         (out) high in CALC and DONE
//            done         (out) one-cycle pulse when the product becomes valid
//            product      (out) signed result, held until the next result
//
// Build option
//   MULT_ZERO_SKIP_EN : when defined, a start with a zero operand goes
//                       straight to DONE with product 0 (latency 1).
//
// State | Meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands are loaded when it is accepted
// CALC  | one Booth add/sub-and-shift per cycle, dw cycles in total
// DONE  | product valid, done pulses; always returns to IDLE
module booth_mult_ctrl #(
  parameter int dw = 8
) (
  input  logic              clk,
  input  logic              reset,
  booth_mult_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(dw + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // A carries a guard bit so that subtracting M = -2^(dw-1) cannot overflow.
  logic [dw:0]       a_q, a_d;
  logic [dw-1:0]     q_q, q_d;
  logic              q1_q, q1_d;
  logic [dw-1:0]     m_q, m_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2*dw-1:0]   product_q, product_d;

  logic              add_sub;
  logic [dw:0]       m_ext;
  logic [dw:0]       adder_out;
  logic [dw:0]       sum;
  logic              last_iter;

  // Shared adder/subtractor: add_sub=1 adds, 0 subtracts.
  assign m_ext     = {m_q[dw-1], m_q};
  assign adder_out = add_sub ? (a_q + m_ext) : (a_q - m_ext);
  // Only the 01/10 Booth pairs use the adder; 00/11 pass A through.
  assign sum       = (q_q[0] ^ q1_q) ? adder_out : a_q;
  assign last_iter = (count_q == CNT_W'(dw - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
`ifdef MULT_ZERO_SKIP_EN
          if ((bus.multiplicand == '0) || (bus.multiplier == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
`else
          state_d = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    add_sub  = 1'b0;
    case (state_q)
      S_CALC: begin
        bus.busy = 1'b1;
        add_sub  = ({q_q[0], q1_q} == 2'b01);
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d       = a_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          m_d     = bus.multiplicand;
          q_d     = bus.multiplier;
          a_d     = '0;
          q1_d    = 1'b0;
          count_d = '0;
`ifdef MULT_ZERO_SKIP_EN
          if ((bus.multiplicand == '0) || (bus.multiplier == '0)) begin
            product_d = '0;
          end
`endif
        end
      end
      S_CALC: begin
        // Arithmetic right shift of {sum, Q, Q_1}, replicating the sum MSB.
        a_d     = {sum[dw], sum[dw:1]};
        q_d     = {sum[0], q_q[dw-1:1]};
        q1_d    = q_q[0];
        count_d = count_q + CNT_W'(1);
        // Capture on the edge that enters DONE so the result is visible
        // in the same cycle as the done pulse.
        if (last_iter) begin
          product_d = {a_d[dw-1:0], q_d};
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign bus.product = product_q;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
module tb_booth_mult_ctrl;
  localparam int DW = 8;
  localparam int PW = 2 * DW;

  logic clk = 1'b0;
  logic reset;

  booth_mult_ctrl_if #(.dw(DW)) bus_if ();

  booth_mult_ctrl #(.dw(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PW-1:0] prod;
    int            done_cyc;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  logic [PW-1:0] last_prod = '0;

  function automatic logic [PW-1:0] ref_mult(logic [DW-1:0] m, logic [DW-1:0] q);
    longint pm, pq;
    pm = longint'($signed(m));
    pq = longint'($signed(q));
    return PW'(pm * pq);
  endfunction

  // Cycles with busy high from the accepting edge until back in IDLE.
  function automatic int ref_lat(logic [DW-1:0] m, logic [DW-1:0] q);
`ifdef MULT_ZERO_SKIP_EN
    if (m == '0 || q == '0) return 1;
`endif
    return DW + 1;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse; also checks that
  // product holds its value between results.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_prod = '0;
    end else if (bus_if.done) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done at cycle %0d product=%0h", cyc, bus_if.product);
      end else begin
        e = sb.pop_front();
        if (bus_if.product !== e.prod) begin
          failures++;
          $display("FAIL product actual=%0h expected=%0h", bus_if.product, e.prod);
        end
        checks++;
        if (cyc != e.done_cyc) begin
          failures++;
          $display("FAIL done_latency actual_cycle=%0d expected_cycle=%0d", cyc, e.done_cyc);
        end
      end
      last_prod = bus_if.product;
    end else begin
      checks++;
      if (bus_if.product !== last_prod) begin
        failures++;
        $display("FAIL product_hold actual=%0h expected=%0h", bus_if.product, last_prod);
      end
    end
  end

  // Waits for IDLE, pulses start for one cycle and returns at the negedge
  // just after the accepting edge. The expectation is pushed before that edge.
  task automatic start_op(input logic [DW-1:0] m, input logic [DW-1:0] q,
                          input logic [PW-1:0] exp_prod, output int acc);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (bus_if.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout busy stuck, actual=1 expected=0");
    end
    bus_if.start        = 1'b1;
    bus_if.multiplicand = m;
    bus_if.multiplier   = q;
    acc        = cyc + 1;
    e.prod     = exp_prod;
    e.done_cyc = acc + ref_lat(m, q) - 1;
    sb.push_back(e);
    @(negedge clk);
    bus_if.start        = 1'b0;
    bus_if.multiplicand = DW'($urandom);
    bus_if.multiplier   = DW'($urandom);
  endtask

  task automatic wait_idle(input int acc, input int lat);
    int n;
    n = 0;
    while (bus_if.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("busy_len", longint'(cyc - acc), longint'(lat));
  endtask

  task automatic run_op(input logic [DW-1:0] m, input logic [DW-1:0] q,
                        input logic [PW-1:0] exp_prod);
    int acc;
    start_op(m, q, exp_prod, acc);
    wait_idle(acc, ref_lat(m, q));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc2;
    int n;
    logic [DW-1:0] rm, rq;
    exp_t e;

    reset               = 1'b1;
    bus_if.start        = 1'b0;
    bus_if.multiplicand = '0;
    bus_if.multiplier   = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", longint'(bus_if.busy), 0);
    chk("reset_done", longint'(bus_if.done), 0);
    chk("reset_product", longint'(bus_if.product), 0);
    reset = 1'b0;

    // Directed products with literal expectations
    run_op(8'd3,   8'd5,   16'h000F);
    run_op(8'hFD,  8'd5,   16'hFFF1);
    run_op(8'h7F,  8'h80,  16'hC080);
    run_op(8'h80,  8'h80,  16'h4000);
    run_op(8'hFF,  8'hFF,  16'h0001);
    run_op(8'd0,   8'd55,  16'h0000);
    run_op(8'd55,  8'd0,   16'h0000);

    // start pulsed during CALC is ignored
    start_op(8'd3, 8'd5, 16'h000F, acc);
    n = 0;
    while (cyc < acc + 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus_if.start        = 1'b1;
    bus_if.multiplicand = 8'd9;
    bus_if.multiplier   = 8'd9;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_idle(acc, DW + 1);
    run_op(8'd9, 8'd9, 16'h0051);

    // reset in the 5th CALC cycle discards the operation
    start_op(8'd7, 8'd7, 16'h0031, acc);
    n = 0;
    while (cyc < acc + 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    sb.delete();
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_busy", longint'(bus_if.busy), 0);
    chk("midreset_done", longint'(bus_if.done), 0);
    chk("midreset_product", longint'(bus_if.product), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (DW + 4) @(negedge clk);
    chk("midreset_idle", longint'(bus_if.busy), 0);
    run_op(8'd2, 8'hFE, 16'hFFFC);

    // start held high: back-to-back accepts separated by one IDLE cycle
    @(negedge clk);
    bus_if.start        = 1'b1;
    bus_if.multiplicand = 8'd5;
    bus_if.multiplier   = 8'd6;
    acc  = cyc + 1;
    acc2 = acc + DW + 2;
    e.prod = 16'h001E; e.done_cyc = acc + DW;  sb.push_back(e);
    e.prod = 16'h001E; e.done_cyc = acc2 + DW; sb.push_back(e);
    n = 0;
    while (cyc < acc2 + DW && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_start_drain", longint'(sb.size()), 0);

    // Randomised operands against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      rm = DW'($urandom);
      rq = DW'($urandom);
      if (i % 7 == 3) rm = '0;
      if (i % 9 == 5) rq = '0;
      if (i % 8 == 1) rm = 8'h80;
      if (i % 10 == 2) rq = 8'h80;
      run_op(rm, rq, ref_mult(rm, rq));
    end

    repeat (5) @(negedge clk);
    chk("sb_drain", longint'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
